// File: rtl/nec_ir_tx.sv
// NEC infrared transmitter: serialises {~Cmd, Cmd, ~Addr, Addr} LSB first, or a repeat
// code, as a mark/space envelope gated by a carrier for an IR LED.
module nec_ir_tx #(
    parameter int UNIT_CYCLES = 28125,
    parameter int CARR_HALF   = 658
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    input  logic       RepeatReq,
    input  logic [7:0] Addr,
    input  logic [7:0] Cmd,
    output logic       IrEnv,
    output logic       IrOut,
    output logic       Busy,
    output logic       Done
);
    localparam int UW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
    localparam int PW = (CARR_HALF > 0) ? $clog2(CARR_HALF + 1) : 1;
    localparam logic [UW-1:0] UNIT_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [PW-1:0] PH_LAST   = PW'(CARR_HALF);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LEAD_MARK  = 3'd1;
    localparam logic [2:0] S_LEAD_SPACE = 3'd2;
    localparam logic [2:0] S_BIT_MARK   = 3'd3;
    localparam logic [2:0] S_BIT_SPACE  = 3'd4;
    localparam logic [2:0] S_STOP_MARK  = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [UW-1:0] r_unit_cnt;
    logic [4:0]    r_units;
    logic [4:0]    w_dur;
    logic [4:0]    r_bit;
    logic [31:0]   r_shift;
    logic          r_repeat;
    logic [PW-1:0] r_ph_cnt;
    logic          r_phase;
    logic          r_busy;
    logic          r_done;
    logic          w_accept;
    logic          w_unit_wrap;
    logic          w_state_end;
    logic          w_mark;

    assign w_accept    = (r_state == S_IDLE) && Start;
    assign w_mark      = (r_state == S_LEAD_MARK) || (r_state == S_BIT_MARK) ||
                         (r_state == S_STOP_MARK);
    assign w_unit_wrap = (r_unit_cnt == UNIT_LAST);
    assign w_state_end = (r_state != S_IDLE) && w_unit_wrap && (r_units == w_dur - 5'd1);

    // State length in NEC units; a one-bit space is three units, a zero-bit space one.
    always_comb begin
        w_dur = 5'd1;
        case (r_state)
            S_LEAD_MARK:  w_dur = 5'd16;
            S_LEAD_SPACE: w_dur = r_repeat ? 5'd4 : 5'd8;
            S_BIT_SPACE:  w_dur = r_shift[0] ? 5'd3 : 5'd1;
            default:      w_dur = 5'd1;
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (Start)       w_next = S_LEAD_MARK;
            S_LEAD_MARK:  if (w_state_end) w_next = S_LEAD_SPACE;
            S_LEAD_SPACE: if (w_state_end) w_next = r_repeat ? S_STOP_MARK : S_BIT_MARK;
            S_BIT_MARK:   if (w_state_end) w_next = S_BIT_SPACE;
            S_BIT_SPACE:  if (w_state_end) w_next = (r_bit == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  if (w_state_end) w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_unit_cnt <= '0;
            r_units    <= '0;
            r_bit      <= '0;
            r_ph_cnt   <= '0;
            r_phase    <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (r_state == S_STOP_MARK) && w_state_end;

            if ((r_state == S_IDLE) || w_state_end) begin
                r_unit_cnt <= '0;
                r_units    <= '0;
            end else if (w_unit_wrap) begin
                r_unit_cnt <= '0;
                r_units    <= r_units + 5'd1;
            end else begin
                r_unit_cnt <= r_unit_cnt + 1'b1;
            end

            if (w_accept) begin
                r_bit <= '0;
            end else if ((r_state == S_BIT_SPACE) && w_state_end) begin
                r_bit <= r_bit + 5'd1;
            end

            // Outside marks the carrier sits at its entry value so every mark starts high.
            if (!w_mark || w_state_end) begin
                r_ph_cnt <= '0;
                r_phase  <= 1'b1;
            end else if (r_ph_cnt == PH_LAST) begin
                r_ph_cnt <= '0;
                r_phase  <= ~r_phase;
            end else begin
                r_ph_cnt <= r_ph_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (w_accept) begin
            r_shift  <= {~Cmd, Cmd, ~Addr, Addr};
            r_repeat <= RepeatReq;
        end else if ((r_state == S_BIT_SPACE) && w_state_end) begin
            r_shift  <= {1'b0, r_shift[31:1]};
        end
    end

    assign IrEnv = w_mark;
    assign IrOut = w_mark & r_phase;
    assign Busy  = r_busy;
    assign Done  = r_done;

endmodule
